// File: rtl/dadda_acc.sv
// rtl/dadda_acc.sv - frame accumulator behind the 8x8 Dadda multiply-add
// Optional build macro: DADDA_ACC_SAT_EN (clamp the frame sum on overflow
// instead of wrapping). Default build wraps modulo 2^ACC_W.
module dadda_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_res,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic             w_accept;
  logic [ACC_W:0]   w_ext;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  // Handshake flags are pure decodes of the registered state, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign overflow  = r_ovf;

  assign w_accept  = in_valid & in_ready;
  // One extra MSB on both operands exposes the carry out of bit ACC_W-1.
  assign w_ext     = {{(ACC_W + 1 - 17){1'b0}}, in_res};
  assign w_sum     = {1'b0, r_acc} + w_ext;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state and datapath update: first beat loads, later beats add.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_ext[ACC_W-1:0];
          w_cnt_nxt   = CNT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = in_last ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (w_accept) begin
`ifdef DADDA_ACC_SAT_EN
          w_acc_nxt   = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
          w_acc_nxt   = w_sum[ACC_W-1:0];
`endif
          w_cnt_nxt   = w_cnt_inc;
          w_ovf_nxt   = r_ovf | w_sum[ACC_W];
          w_state_nxt = in_last ? S_HOLD : S_ACC;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dadda_acc.sv
// tb/tb_dadda_acc.sv - randomized self-checking bench for dadda_acc (24- and 17-bit builds)
module tb_dadda_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [16:0] in_res;

  logic        rdy_a, vld_a, ovf_a;
  logic [23:0] sum_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [16:0] sum_b;
  logic [7:0]  cnt_b;

  int     n_vec  = 0;
  int     n_miss = 0;
  longint m_sum  = 0;
  int     m_n    = 0;

  always #5 clk = ~clk;

  dadda_acc #(.ACC_W(24), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_res(in_res),
    .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready), .out_sum(sum_a),
    .out_count(cnt_a), .overflow(ovf_a)
  );

  dadda_acc #(.ACC_W(17), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_res(in_res),
    .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready), .out_sum(sum_b),
    .out_count(cnt_b), .overflow(ovf_b)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: true arithmetic frame sum, then wrapped or clamped to w bits.
  function automatic longint exp_sum(input int w);
    longint lim;
    lim = longint'(1) << w;
    if (m_sum >= lim) begin
`ifdef DADDA_ACC_SAT_EN
      return lim - 1;
`else
      return m_sum % lim;
`endif
    end
    return m_sum;
  endfunction

  function automatic longint exp_ovf(input int w);
    return (m_sum >= (longint'(1) << w)) ? 1 : 0;
  endfunction

  function automatic longint exp_cnt();
    return (m_n > 255) ? 255 : m_n;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [16:0] res, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_res   = res;
    in_last  = last;
    while (!rdy_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_sum += longint'(res);
    m_n++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_result(input string tag);
    check_eq({tag, "_valid_a"}, vld_a, 1);
    check_eq({tag, "_valid_b"}, vld_b, 1);
    check_eq({tag, "_ready_a"}, rdy_a, 0);
    check_eq({tag, "_ready_b"}, rdy_b, 0);
    check_eq({tag, "_sum_a"}, sum_a, exp_sum(24));
    check_eq({tag, "_sum_b"}, sum_b, exp_sum(17));
    check_eq({tag, "_cnt_a"}, cnt_a, exp_cnt());
    check_eq({tag, "_cnt_b"}, cnt_b, exp_cnt());
    check_eq({tag, "_ovf_a"}, ovf_a, exp_ovf(24));
    check_eq({tag, "_ovf_b"}, ovf_b, exp_ovf(17));
  endtask

  // Called right after the last beat: result must already be visible,
  // held for `hold` stalled cycles, then released with a one-cycle bubble.
  task automatic check_frame(input string tag, input int hold);
    check_result(tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_result({tag, "_hold"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_drop_a"}, vld_a, 0);
    check_eq({tag, "_drop_b"}, vld_b, 0);
    check_eq({tag, "_rdy_back_a"}, rdy_a, 1);
    check_eq({tag, "_rdy_back_b"}, rdy_b, 1);
    m_sum = 0;
    m_n   = 0;
  endtask

  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_res    = 17'h01234;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", rdy_a, 1);
    check_eq("rst_valid", vld_a, 0);
    check_eq("rst_sum", sum_a, 0);
    check_eq("rst_cnt", cnt_a, 0);
    check_eq("rst_ovf", ovf_a, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // Two-beat frame: 0x0A956 + 0x0FE01 = 0x1A757
    beat(17'h0A956, 1'b0);
    beat(17'h0FE01, 1'b1);
    check_eq("two_sum_const", sum_a, 24'h01A757);
    check_frame("two", 0);

    // Backpressure with a pending beat that must be ignored while holding
    beat(17'h1FFFF, 1'b1);
    in_valid = 1'b1;
    in_res   = 17'h00033;
    in_last  = 1'b1;
    check_frame("bp", 5);
    beat(17'h00033, 1'b1);
    check_frame("bp_next", 0);

    // Overflow in the 17-bit build
    beat(17'h1FFFF, 1'b0);
    beat(17'h00002, 1'b1);
`ifdef DADDA_ACC_SAT_EN
    check_eq("ovf17_sum_const", sum_b, 17'h1FFFF);
`else
    check_eq("ovf17_sum_const", sum_b, 17'h00001);
`endif
    check_frame("ovf", 1);

    // Stalled input: gaps between beats do not disturb the sum
    beat(17'h00010, 1'b0);
    idle(2);
    beat(17'h00010, 1'b0);
    beat(17'h00010, 1'b1);
    check_eq("stall_sum_const", sum_a, 24'h000030);
    check_frame("stall", 0);

    // Reset in the middle of a frame, asserted between clock edges
    beat(17'h00100, 1'b0);
    beat(17'h00200, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_ready", rdy_a, 1);
    check_eq("mrst_valid", vld_a, 0);
    check_eq("mrst_sum", sum_a, 0);
    check_eq("mrst_cnt", cnt_b, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_sum = 0;
    m_n   = 0;
    @(negedge clk);
    check_eq("mrst_no_valid", vld_a, 0);
    beat(17'h00005, 1'b1);
    check_frame("mrst", 0);

    // Randomized frames with random gaps and random backpressure
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        beat(17'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
        if (b != len - 1) idle($urandom_range(0, 2));
      end
      check_frame("rnd", $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    // Long frame: count saturates at 255, both widths overflow
    for (int b = 0; b < 260; b++) begin
      beat(17'($urandom), (b == 259) ? 1'b1 : 1'b0);
    end
    check_frame("long", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
